// File: rtl/mmio_pkg.sv
// Shared types and constants for the memory-mapped bus router.
package mmio_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_t;

    // Default device map, one 4 KiB region per device.
    localparam int unsigned DevDram  = 0;
    localparam int unsigned DevDrom  = 1;
    localparam int unsigned DevDmat  = 2;
    localparam int unsigned DevDint  = 3;
    localparam int unsigned DevDreg  = 4;
    localparam int unsigned DevDexec = 5;
    localparam int unsigned DevDspi  = 6;

    function automatic int unsigned miss_did(input int unsigned did_w);
        return (32'd1 << did_w) - 32'd1;
    endfunction

endpackage

// File: rtl/mmio_region_decode.sv
// Combinational region decoder: maps an address onto a device index.
module mmio_region_decode
    import mmio_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned REGION_BITS = 12,
    parameter int unsigned N_DEV       = 7,
    localparam int unsigned DID_W      = $clog2(N_DEV + 1)
) (
    input  logic              rd_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_o,
    output logic [DID_W-1:0]  did_o
);

    localparam int unsigned IdxW = ADDR_W - REGION_BITS;

    logic [IdxW-1:0] idx;
    logic            hit;
    logic            unused_offset;

    assign idx           = addr_i[ADDR_W-1:REGION_BITS];
    assign unused_offset = ^addr_i[REGION_BITS-1:0];

    always_comb begin
        hit   = (rd_i | wr_i) && (idx < IdxW'(N_DEV));
        // DID_W never exceeds IdxW because N_DEV < 2**IdxW.
        did_o = hit ? idx[DID_W-1:0] : DID_W'(miss_did(DID_W));
        hit_o = hit;
    end

endmodule

// File: rtl/mmio_router.sv
// Bus router: decodes a master request, strobes one device, waits for ack or timeout.
module mmio_router
    import mmio_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned REGION_BITS = 12,
    parameter int unsigned N_DEV       = DevDspi + 1,
    parameter int unsigned TIMEOUT     = 15,
    localparam int unsigned DID_W      = $clog2(N_DEV + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    rd_i,
    input  logic                    wr_i,
    input  logic [ADDR_W-1:0]       addr_i,
    input  logic [DATA_W-1:0]       wdata_i,
    output logic [DATA_W-1:0]       rdata_o,
    output logic                    ready_o,
    output logic                    err_o,
    output logic                    busy_o,
    output logic                    hit_o,
    output logic [DID_W-1:0]        did_o,
    output logic [N_DEV-1:0]        dev_sel_o,
    output logic                    dev_rd_o,
    output logic                    dev_wr_o,
    output logic [REGION_BITS-1:0]  dev_addr_o,
    output logic [DATA_W-1:0]       dev_wdata_o,
    input  logic [N_DEV*DATA_W-1:0] dev_rdata_i,
    input  logic [N_DEV-1:0]        dev_ack_i
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic                   op_wr_q, op_wr_d;
    logic [DID_W-1:0]       did_q, did_d;
    logic [REGION_BITS-1:0] offs_q, offs_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [CntW-1:0]        cnt_q, cnt_d;

    logic                   hit;
    logic [DID_W-1:0]       did;
    logic                   ack_sel;
    logic [DATA_W-1:0]      rdata_sel;
    logic [N_DEV-1:0]       sel_onehot;
    logic                   in_access;

    mmio_region_decode #(
        .ADDR_W      (ADDR_W),
        .REGION_BITS (REGION_BITS),
        .N_DEV       (N_DEV)
    ) u_decode (
        .rd_i   (rd_i),
        .wr_i   (wr_i),
        .addr_i (addr_i),
        .hit_o  (hit),
        .did_o  (did)
    );

    // Only the latched device's ack and data slice are ever observed.
    always_comb begin
        ack_sel    = 1'b0;
        rdata_sel  = '0;
        sel_onehot = '0;
        for (int k = 0; k < int'(N_DEV); k++) begin
            if (did_q == DID_W'(k)) begin
                ack_sel       = dev_ack_i[k];
                rdata_sel     = dev_rdata_i[k*DATA_W +: DATA_W];
                sel_onehot[k] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        op_wr_d = op_wr_q;
        did_d   = did_q;
        offs_d  = offs_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if ((rd_i ^ wr_i) && hit) begin
                    op_wr_d = wr_i;
                    did_d   = did;
                    offs_d  = addr_i[REGION_BITS-1:0];
                    wdata_d = wdata_i;
                    cnt_d   = '0;
                    state_d = StAccess;
                end else if (rd_i | wr_i) begin
                    // Miss or rd/wr conflict: answer with an error, never touch a device.
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StAccess: begin
                if (ack_sel) begin
                    rdata_d = op_wr_q ? '0 : rdata_sel;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == CntLast) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            op_wr_q <= 1'b0;
            did_q   <= '0;
            offs_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_wr_q <= op_wr_d;
            did_q   <= did_d;
            offs_q  <= offs_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_access   = (state_q == StAccess);
    assign busy_o      = (state_q != StIdle);
    assign ready_o     = (state_q == StResp);
    assign err_o       = ready_o & err_q;
    assign rdata_o     = rdata_q;
    assign dev_sel_o   = in_access ? sel_onehot : '0;
    assign dev_rd_o    = in_access & ~op_wr_q;
    assign dev_wr_o    = in_access & op_wr_q;
    assign dev_addr_o  = offs_q;
    assign dev_wdata_o = wdata_q;
    assign hit_o       = hit;
    assign did_o       = did;

endmodule

// File: tb/tb_mmio_router.sv
// Randomised self-checking bench for mmio_router against a transaction-level model.
module tb_mmio_router;

    localparam int NDev    = 7;
    localparam int DataW   = 16;
    localparam int Timeout = 15;
    localparam int DidW    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst, rd, wr;
    logic [15:0]           addr, wdata;
    logic [DataW-1:0]      rdata;
    logic                  ready, err, busy, hit;
    logic [DidW-1:0]       did;
    logic [NDev-1:0]       dev_sel;
    logic                  dev_rd, dev_wr;
    logic [11:0]           dev_addr;
    logic [DataW-1:0]      dev_wdata;
    logic [NDev*DataW-1:0] dev_rdata;
    logic [NDev-1:0]       dev_ack;

    // Second build: 3 devices, 8 KiB regions; only its decode outputs are checked.
    logic        rd2;
    logic [15:0] addr2;
    logic        hit2;
    logic [1:0]  did2;
    logic [15:0] rdata2, dev_wdata2;
    logic        ready2, err2, busy2, dev_rd2, dev_wr2;
    logic [2:0]  dev_sel2;
    logic [12:0] dev_addr2;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [15:0] dev_mem [NDev];

    mmio_router dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rd_i        (rd),
        .wr_i        (wr),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rdata_o     (rdata),
        .ready_o     (ready),
        .err_o       (err),
        .busy_o      (busy),
        .hit_o       (hit),
        .did_o       (did),
        .dev_sel_o   (dev_sel),
        .dev_rd_o    (dev_rd),
        .dev_wr_o    (dev_wr),
        .dev_addr_o  (dev_addr),
        .dev_wdata_o (dev_wdata),
        .dev_rdata_i (dev_rdata),
        .dev_ack_i   (dev_ack)
    );

    mmio_router #(.N_DEV(3), .REGION_BITS(13)) dut2 (
        .clk_i       (clk),
        .rst_i       (rst),
        .rd_i        (rd2),
        .wr_i        (1'b0),
        .addr_i      (addr2),
        .wdata_i     (16'h0),
        .rdata_o     (rdata2),
        .ready_o     (ready2),
        .err_o       (err2),
        .busy_o      (busy2),
        .hit_o       (hit2),
        .did_o       (did2),
        .dev_sel_o   (dev_sel2),
        .dev_rd_o    (dev_rd2),
        .dev_wr_o    (dev_wr2),
        .dev_addr_o  (dev_addr2),
        .dev_wdata_o (dev_wdata2),
        .dev_rdata_i (48'h0),
        .dev_ack_i   (3'b0)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Transaction-level expectation from the address map and the ack timing.
    function automatic void model(input logic r, input logic w, input logic [15:0] a,
                                  input int ack_delay, input int ack_dev,
                                  output int lat, output logic e, output logic [15:0] rdt,
                                  output int acc);
        int region;
        region = int'(a >> 12);
        if ((r && w) || region >= NDev) begin
            lat = 1; e = 1'b1; rdt = 16'h0; acc = 0;
        end else if (ack_dev == region && ack_delay >= 0 && ack_delay < Timeout) begin
            lat = ack_delay + 2; e = 1'b0; rdt = r ? dev_mem[region] : 16'h0; acc = ack_delay + 1;
        end else begin
            lat = Timeout + 1; e = 1'b1; rdt = 16'h0; acc = Timeout;
        end
    endfunction

    task automatic pack_mem();
        for (int k = 0; k < NDev; k++) dev_rdata[k*DataW +: DataW] = dev_mem[k];
    endtask

    // Drives one request and records what the DUT does; judging is left to the callers.
    task automatic run_txn(input logic r, input logic w, input logic [15:0] a,
                           input logic [15:0] d, input int ack_delay, input int ack_dev,
                           output logic o_hit, output logic [DidW-1:0] o_did,
                           output int lat, output logic e, output logic [15:0] rdt,
                           output int sel_cycles, output logic [NDev-1:0] sel_union,
                           output int rd_cycles, output int wr_cycles,
                           output int extra_ready, output logic held_ok);
        lat = 0; e = 1'bx; rdt = 16'hxxxx; sel_cycles = 0; sel_union = '0;
        rd_cycles = 0; wr_cycles = 0; extra_ready = 0; held_ok = 1'b1;
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = d;
        #1;
        o_hit = hit; o_did = did;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                rd = 1'b0; wr = 1'b0; addr = 16'($urandom); wdata = 16'($urandom);
            end
            dev_ack = '0;
            if (ack_delay >= 0 && c == ack_delay + 1 && ack_dev < NDev) dev_ack[ack_dev] = 1'b1;
            #1;
            if (ready === 1'b1) begin
                if (lat == 0) begin
                    lat = c; e = err; rdt = rdata;
                end else begin
                    extra_ready++;
                end
            end
            if (dev_sel !== '0) begin
                sel_cycles++;
                sel_union = sel_union | dev_sel;
                if (dev_addr !== a[11:0] || (w && dev_wdata !== d)) held_ok = 1'b0;
            end
            if (dev_rd === 1'b1) rd_cycles++;
            if (dev_wr === 1'b1) wr_cycles++;
            if (lat != 0 && c >= lat + 2 && c >= ack_delay + 2) break;
        end
        dev_ack = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({ready, err, busy, dev_rd, dev_wr} !== 5'b0)
            $display("FAIL reset_flags got %b want 00000", {ready, err, busy, dev_rd, dev_wr});
        else pass_cnt++;
        total_cnt++;
        if ({rdata, dev_sel, dev_addr, dev_wdata} !== '0)
            $display("FAIL reset_data got %h/%b/%h/%h want zeros", rdata, dev_sel, dev_addr, dev_wdata);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_read_hit();
        logic h, e, ho; logic [DidW-1:0] dd; logic [15:0] rdt, erd;
        int lat, sc, rc, wc, xr, elat, acc; logic [NDev-1:0] su;
        for (int k = 0; k < NDev; k++) dev_mem[k] = 16'($urandom);
        dev_mem[4] = 16'hBEEF;
        pack_mem();
        model(1'b1, 1'b0, 16'h4000, 0, 4, elat, e, erd, acc);
        run_txn(1'b1, 1'b0, 16'h4000, 16'h5555, 0, 4, h, dd, lat, e, rdt, sc, su, rc, wc, xr, ho);
        total_cnt++;
        if ({h, dd} !== {1'b1, 3'd4}) $display("FAIL read_decode got %b/%0d want 1/4", h, dd);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 2 || elat != 2) $display("FAIL read_latency got %0d want 2", lat);
        else pass_cnt++;
        total_cnt++;
        if (e !== 1'b0 || rdt !== 16'hBEEF)
            $display("FAIL read_resp got err=%b rdata=%h want err=0 rdata=beef", e, rdt);
        else pass_cnt++;
        total_cnt++;
        if (su !== 7'b0010000 || sc !== 1 || rc !== 1 || wc !== 0)
            $display("FAIL read_strobe got sel=%b cyc=%0d rd=%0d wr=%0d want 0010000/1/1/0",
                     su, sc, rc, wc);
        else pass_cnt++;
    endtask

    task automatic test_write_wait();
        logic h, e, ho; logic [DidW-1:0] dd; logic [15:0] rdt;
        int lat, sc, rc, wc, xr; logic [NDev-1:0] su;
        run_txn(1'b0, 1'b1, 16'h1ABC, 16'h1234, 3, 1, h, dd, lat, e, rdt, sc, su, rc, wc, xr, ho);
        total_cnt++;
        if (ho !== 1'b1 || sc !== 4 || wc !== 4 || su !== 7'b0000010)
            $display("FAIL write_hold got held=%b cyc=%0d wr=%0d sel=%b want 1/4/4/0000010",
                     ho, sc, wc, su);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 5 || e !== 1'b0 || rdt !== 16'h0)
            $display("FAIL write_resp got lat=%0d err=%b rdata=%h want 5/0/0000", lat, e, rdt);
        else pass_cnt++;
    endtask

    task automatic test_miss_conflict();
        logic h, e, ho; logic [DidW-1:0] dd; logic [15:0] rdt;
        int lat, sc, rc, wc, xr; logic [NDev-1:0] su;
        run_txn(1'b1, 1'b0, 16'h7000, 16'h0, 0, 6, h, dd, lat, e, rdt, sc, su, rc, wc, xr, ho);
        total_cnt++;
        if ({h, dd} !== {1'b0, 3'd7}) $display("FAIL miss_decode got %b/%0d want 0/7", h, dd);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 1 || e !== 1'b1 || sc !== 0)
            $display("FAIL miss_resp got lat=%0d err=%b selcyc=%0d want 1/1/0", lat, e, sc);
        else pass_cnt++;
        run_txn(1'b1, 1'b1, 16'h0000, 16'h0, 0, 0, h, dd, lat, e, rdt, sc, su, rc, wc, xr, ho);
        total_cnt++;
        if ({h, dd} !== {1'b1, 3'd0}) $display("FAIL conflict_decode got %b/%0d want 1/0", h, dd);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 1 || e !== 1'b1 || sc !== 0)
            $display("FAIL conflict_resp got lat=%0d err=%b selcyc=%0d want 1/1/0", lat, e, sc);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        logic h, e, ho; logic [DidW-1:0] dd; logic [15:0] rdt;
        int lat, sc, rc, wc, xr; logic [NDev-1:0] su;
        // Ack from device 6 lands one cycle after the error response.
        run_txn(1'b1, 1'b0, 16'h6FFF, 16'h0, 16, 6, h, dd, lat, e, rdt, sc, su, rc, wc, xr, ho);
        total_cnt++;
        if (lat !== 16 || e !== 1'b1 || rdt !== 16'h0 || sc !== 15)
            $display("FAIL timeout_resp got lat=%0d err=%b rdata=%h selcyc=%0d want 16/1/0000/15",
                     lat, e, rdt, sc);
        else pass_cnt++;
        total_cnt++;
        if (xr !== 0) $display("FAIL timeout_late_ack got %0d extra ready want 0", xr);
        else pass_cnt++;
        dev_mem[6] = 16'hA5C3;
        pack_mem();
        run_txn(1'b1, 1'b0, 16'h6000, 16'h0, 14, 6, h, dd, lat, e, rdt, sc, su, rc, wc, xr, ho);
        total_cnt++;
        if (lat !== 16 || e !== 1'b0 || rdt !== 16'hA5C3)
            $display("FAIL ack_on_last_count got lat=%0d err=%b rdata=%h want 16/0/a5c3",
                     lat, e, rdt);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        logic h, e, ho; logic [DidW-1:0] dd; logic [15:0] rdt;
        int lat, sc, rc, wc, xr, stray; logic [NDev-1:0] su;
        @(negedge clk);
        rd = 1'b1; addr = 16'h2000;
        @(negedge clk);
        rd = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if ({busy, ready} !== 2'b00 || dev_sel !== '0)
            $display("FAIL abort_state got busy=%b ready=%b sel=%b want 0/0/0", busy, ready, dev_sel);
        else pass_cnt++;
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (ready !== 1'b0) stray++;
        end
        total_cnt++;
        if (stray !== 0) $display("FAIL abort_no_ready got %0d ready pulses want 0", stray);
        else pass_cnt++;
        dev_mem[0] = 16'h0F0F;
        pack_mem();
        run_txn(1'b1, 1'b0, 16'h0FFF, 16'h0, 1, 0, h, dd, lat, e, rdt, sc, su, rc, wc, xr, ho);
        total_cnt++;
        if ({h, dd} !== {1'b1, 3'd0} || lat !== 3 || e !== 1'b0 || rdt !== 16'h0F0F)
            $display("FAIL post_abort_read got hit=%b did=%0d lat=%0d err=%b rdata=%h want 1/0/3/0/0f0f",
                     h, dd, lat, e, rdt);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic r, w, h, e, ho, ee; logic [DidW-1:0] dd; logic [15:0] a, d, rdt, erd;
        int lat, sc, rc, wc, xr, elat, acc, region, op, dly, adev;
        logic [NDev-1:0] su, esu;
        for (int i = 0; i < 30; i++) begin
            for (int k = 0; k < NDev; k++) dev_mem[k] = 16'($urandom);
            pack_mem();
            op = $urandom_range(0, 9);
            r = (op <= 5); w = (op == 0) || (op >= 6);
            a = 16'($urandom);
            if ($urandom_range(0, 3) != 0) a[15:12] = 4'($urandom_range(0, NDev - 1));
            d = 16'($urandom);
            region = int'(a >> 12);
            dly = $urandom_range(0, 17);
            adev = ($urandom_range(0, 4) == 0) ? $urandom_range(0, NDev - 1) : region;
            model(r, w, a, dly, adev, elat, ee, erd, acc);
            run_txn(r, w, a, d, dly, adev, h, dd, lat, e, rdt, sc, su, rc, wc, xr, ho);
            esu = (acc > 0) ? (NDev'(1) << region) : '0;
            total_cnt++;
            if (lat !== elat || e !== ee || rdt !== erd)
                $display("FAIL rand_resp[%0d] got lat=%0d err=%b rdata=%h want %0d/%b/%h",
                         i, lat, e, rdt, elat, ee, erd);
            else pass_cnt++;
            total_cnt++;
            if (sc !== acc || su !== esu || rc !== ((r && !w) ? acc : 0) ||
                wc !== ((w && !r) ? acc : 0) || ho !== 1'b1 || xr !== 0)
                $display("FAIL rand_strobe[%0d] got cyc=%0d sel=%b rd=%0d wr=%0d held=%b extra=%0d want cyc=%0d sel=%b",
                         i, sc, su, rc, wc, ho, xr, acc, esu);
            else pass_cnt++;
        end
    endtask

    task automatic test_param_sweep();
        @(negedge clk);
        rd2 = 1'b1; addr2 = 16'h4000;
        #1;
        total_cnt++;
        if ({hit2, did2} !== {1'b1, 2'd2}) $display("FAIL sweep_hit got %b/%0d want 1/2", hit2, did2);
        else pass_cnt++;
        addr2 = 16'h6000;
        #1;
        total_cnt++;
        if ({hit2, did2} !== {1'b0, 2'd3}) $display("FAIL sweep_miss got %b/%0d want 0/3", hit2, did2);
        else pass_cnt++;
        addr2 = 16'h3FFF;
        #1;
        total_cnt++;
        if ({hit2, did2} !== {1'b1, 2'd1}) $display("FAIL sweep_edge got %b/%0d want 1/1", hit2, did2);
        else pass_cnt++;
        rd2 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        dev_ack = '0; dev_rdata = '0; rd2 = 1'b0; addr2 = '0;
        for (int k = 0; k < NDev; k++) dev_mem[k] = '0;
        test_reset();
        test_read_hit();
        test_write_wait();
        test_miss_conflict();
        test_timeout();
        test_reset_abort();
        test_random();
        test_param_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mmio_router.md
# mmio_router

Parametrised memory-mapped bus router that replaces the purely combinational region decoder with a transaction engine. It decodes a master `rd`/`wr` request into one of `N_DEV` equal-size address regions and drives a one-hot select and a strobe to the chosen device. It then waits for that device's acknowledge, or for a timeout, and returns read data plus an `ready`/`err` response to the master. It sits between the CPU bus master and the memory-mapped peripherals (DRAM, DROM, DMAT, DINT, DREG, DEXEC, DSPI in the default build).

## Interface
Reset is synchronous and active-high, on a single clock: `clk` rising edge, `rst`.

Parameters:
- `ADDR_W`, 16: master address width.
- `DATA_W`, 16: data width.
- `REGION_BITS`, 12: log2 of region size (0x1000 bytes).
- `N_DEV`, 7: number of devices. Must satisfy 1 ≤ `N_DEV` < 2^(`ADDR_W`−`REGION_BITS`).
- `TIMEOUT`, 15: ACCESS cycles without ack before the bus errors out. Must be ≥ 1.
- `DID_W`: derived, $clog2(`N_DEV`+1).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `rd`  in  1  master read request.
- `wr`  in  1  master write request.
- `addr`  in  `ADDR_W`  master address.
- `wdata`  in  `DATA_W`  master write data.
- `rdata`  out  `DATA_W`  read data, valid while `ready`=1.
- `ready`  out  1  one-cycle transaction-complete pulse.
- `err`  out  1  qualifies `ready`: miss, rd&wr conflict, or timeout.
- `busy`  out  1  a transaction is in progress (state ≠ IDLE).
- `hit`  out  1  combinational: (`rd`|`wr`) and the region of `addr` is < `N_DEV`.
- `did`  out  `DID_W`  combinational region index of `addr`; all-ones when `hit`=0.
- `dev_sel`  out  `N_DEV`  one-hot device select.
- `dev_rd`  out  1  read strobe to the selected device.
- `dev_wr`  out  1  write strobe to the selected device.
- `dev_addr`  out  `REGION_BITS`  region offset, `addr[REGION_BITS-1:0]`.
- `dev_wdata`  out  `DATA_W`  latched write data.
- `dev_rdata`  in  `N_DEV*DATA_W`  device read data; device k occupies slice [k*DATA_W +: DATA_W].
- `dev_ack`  in  `N_DEV`  device acknowledge.

## Operation
Decode:
- Region index is `addr[ADDR_W-1:REGION_BITS]`.
- A hit requires index < `N_DEV` and (`rd`|`wr`).
- On a hit, `did` = index. On a miss or when idle, `did` = all-ones (7 in the default build).
- `rd`&`wr` both high still decodes as a hit, so `hit`/`did` stay pure address decode.

FSM states: IDLE, ACCESS, RESP.

IDLE:
- If `rd`^`wr` and the address hits: latch op, `did`, offset and `wdata`; clear the timeout counter; go to ACCESS.
- If (`rd`|`wr`) but the address misses, or `rd`&`wr` are both high: latch err=1; go to RESP. No device strobe is issued.
- Otherwise stay in IDLE.

ACCESS:
- `dev_sel[did]`=1, with `dev_rd` or `dev_wr` set per the latched op. `dev_addr`/`dev_wdata` are held stable.
- If `dev_ack[did]`=1: capture `dev_rdata` slice `did` (reads only; writes capture 0); err=0; go to RESP.
- Else, if counter = `TIMEOUT`−1: rdata=0, err=1; go to RESP.
- Else increment the counter.
- Acks from non-selected devices are ignored.

RESP:
- `ready`=1 and `err`/`rdata` are presented for exactly one cycle; all `dev_*` strobes and `dev_sel` = 0.
- Next state is IDLE.
- `rd`/`wr` are ignored in RESP. The master must deassert them in the cycle after `ready`, or a new transaction starts.

A late ack arriving after a timeout, or in IDLE/RESP, is ignored.

## Timing
- Every registered output resets to 0: `rdata`, `ready`, `err`, `busy`, `dev_sel`, `dev_rd`, `dev_wr`, `dev_addr`, `dev_wdata`. State resets to IDLE and the counter to 0.
- `rst` asserted mid-transaction aborts it at the next edge. No `ready` is generated for the aborted transaction.
- Hit, ack in the first ACCESS cycle: request sampled at edge n, ACCESS during n..n+1, `ready` high during cycle n+2. Minimum latency is 2 cycles.
- Miss or conflict: `ready`(`err`=1) high in cycle n+1.
- Timeout: `ready`(`err`=1) in cycle n+1+`TIMEOUT`.
- `busy` is high from cycle n+1 through the RESP cycle inclusive.
- An ack in the same cycle as the final timeout count wins: ack has priority and err=0.

## Structure
- Package `mmio_pkg` holds:
  - the `state_t` enum (IDLE, ACCESS, RESP);
  - the miss-code function returning all-ones of `DID_W`;
  - the default-map localparams (DRAM=0 … DSPI=6).
- Sub-module `mmio_region_decode`: combinational, parametrised (`ADDR_W`, `REGION_BITS`, `N_DEV`). Inputs `rd`, `wr`, `addr`; outputs `hit`, `did`. The router instantiates it once.

## Test plan
- Reset, then read at 0x4000 with `dev_ack[4]` returned in the first ACCESS cycle and `dev_rdata` slice 4 = 0xBEEF:
  - `dev_sel`=0b0010000 and `dev_rd`=1 for 1 cycle;
  - `ready`=1, `err`=0, `rdata`=0xBEEF two cycles after the request.
- Write 0x1ABC with `wdata`=0x1234, device 1 acks after 3 cycles:
  - `dev_addr`=0xABC, `dev_wdata`=0x1234 held for 4 cycles;
  - `ready`=1, `err`=0.
- Miss at 0x7000, and rd=wr=1 at 0x0000:
  - `ready`=1, `err`=1 one cycle after the request; `dev_sel` stays 0;
  - `hit`/`did` read 0/7 and 1/0 respectively.
- Read at 0x6FFF with no ack:
  - `ready`=1, `err`=1, `rdata`=0 in cycle n+16;
  - an ack from device 6 one cycle later produces no second `ready`.
- `rst` pulsed during ACCESS:
  - next cycle `busy`=0, `dev_sel`=0, `ready`=0;
  - a new read to 0x0FFF then completes normally with `did`=0.
- Parameter sweep `N_DEV`=3, `REGION_BITS`=13:
  - 0x4000 hits `did`=2;
  - 0x6000 misses with `did`=3 (all-ones).
